// File: rtl/dmem_pkg.sv
// Shared encodings and lane-steering helpers for the data-memory responder.
`timescale 1ns/1ps
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Big-endian lanes: offset 0 lives in bits [31:24], be[3].
  function automatic logic [3:0] lane_be(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (size == SZ_BYTE): be = 4'b1000 >> off;
      (size == SZ_HALF): be = off[1] ? 4'b0011 : 4'b1100;
      default:           be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_store(
    input logic [31:0] wd,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = wd;
    unique case (1'b1)
      (size == SZ_BYTE): r = {4{wd[7:0]}};
      (size == SZ_HALF): r = {2{wd[15:0]}};
      default:           r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_load(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[31:24];
    unique case (off)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    r = w;
    unique case (1'b1)
      (size == SZ_BYTE): r = {{24{sgn & b[7]}}, b};
      (size == SZ_HALF): r = {{16{sgn & h[15]}}, h};
      default:           r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised byte store: 4-lane byte-enable write, combinational read.
`timescale 1ns/1ps
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 1024,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  localparam int WORDS = DEPTH_BYTES / 4;

  logic [31:0] mem_q [WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with wait states; DMEM_ERR_CHECK_EN enables
// misalign/range/size checking, otherwise addresses wrap and align.
`timescale 1ns/1ps
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam int IDX_W  = ADDR_W - 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT_M1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  req_t             req_q, req_in, acc;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             hs, fire, acc_err, we;
  logic [1:0]       eff_size, eff_off;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      mem_wdata, mem_rdata;

  assign req_in = '{
    write: req_write,
    size:  req_size,
    sgn:   req_signed,
    addr:  req_addr,
    wdata: req_wdata
  };

  assign hs = req_valid & req_ready;

  // With zero latency the access happens on the acceptance edge itself.
  assign acc = (state_q == S_IDLE) ? req_in : req_q;

  always_comb begin
    fire = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): fire = hs && (LATENCY == 0);
      (state_q == S_WAIT): fire = (cnt_q == '0);
      default:             fire = 1'b0;
    endcase
  end

`ifdef DMEM_ERR_CHECK_EN
  assign eff_size = acc.size;
  assign eff_off  = acc.addr[1:0];
  assign idx      = acc.addr[ADDR_W-1:2];

  always_comb begin
    acc_err = 1'b0;
    if (acc.size == SZ_RSVD) acc_err = 1'b1;
    if (|acc.addr[31:ADDR_W]) acc_err = 1'b1;
    if (acc.size == SZ_HALF && acc.addr[0]) acc_err = 1'b1;
    if (acc.size == SZ_WORD && |acc.addr[1:0]) acc_err = 1'b1;
  end
`else
  logic unused_hi;

  assign eff_size  = (acc.size == SZ_RSVD) ? SZ_WORD : acc.size;
  assign idx       = acc.addr[ADDR_W-1:2];
  assign acc_err   = 1'b0;
  assign unused_hi = ^acc.addr[31:ADDR_W];

  always_comb begin
    eff_off = 2'b00;
    unique case (1'b1)
      (eff_size == SZ_BYTE): eff_off = acc.addr[1:0];
      (eff_size == SZ_HALF): eff_off = {acc.addr[1], 1'b0};
      default:               eff_off = 2'b00;
    endcase
  end
`endif

  assign we        = fire & acc.write & ~acc_err;
  assign be        = lane_be(eff_size, eff_off);
  assign mem_wdata = lane_store(acc.wdata, eff_size);

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .be_i    (be),
    .idx_i   (idx),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    rdata_d = '0;
    err_d   = acc_err;
    if (!acc_err && !acc.write)
      rdata_d = lane_load(mem_rdata, eff_size, eff_off, acc.sgn);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst & (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (hs) req_q <= req_in;
      if (fire) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: timing, endianness, backpressure, errors, reset.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_BYTES (1024),
    .ADDR_W      (10),
    .LATENCY     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic drive(input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int cyc);
    int t;
    t = 0;
    drive(w, sz, sg, a, wd);
    while (!req_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) begin
      n_run++; n_fail++;
      $display("FAIL accept_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_run++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_req_ready got=%b exp=0", req_ready);
    end
    n_run++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid);
    end
    n_run++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rsp_data got=%h/%b exp=0/0", rsp_rdata, rsp_err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_run++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_ready got=%b exp=1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int cyc;
    do_req(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, rd, er, cyc);
    n_run++;
    if (cyc !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL word_store cyc=%0d rd=%h err=%b exp 3/0/0", cyc, rd, er);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL word_load got=%h exp=deadbeef", rd);
    end
    n_run++;
    if (cyc !== 3) begin
      n_fail++; $display("FAIL word_load_lat got=%0d exp=3", cyc);
    end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int cyc;
    logic [31:0] exp_v [5];
    logic [1:0]  sz_v  [5];
    logic        sg_v  [5];
    logic [31:0] a_v   [5];
    a_v = '{32'h011, 32'h011, 32'h012, 32'h010, 32'h013};
    sz_v = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    sg_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_v = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF,
              32'h0000DEAD, 32'hFFFFFFEF};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sz_v[i], sg_v[i], a_v[i], 32'h0, rd, er, cyc);
      n_run++;
      if (rd !== exp_v[i]) begin
        n_fail++;
        $display("FAIL extend_%0d addr=%h got=%h exp=%h", i, a_v[i], rd, exp_v[i]);
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int cyc;
    do_req(1'b1, 2'd0, 1'b0, 32'h013, 32'hFFFFFF55, rd, er, cyc);
    do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'hDEADBE55) begin
      n_fail++; $display("FAIL byte_store got=%h exp=deadbe55", rd);
    end
    do_req(1'b1, 2'd2, 1'b0, 32'h014, 32'h0, rd, er, cyc);
    do_req(1'b1, 2'd1, 1'b0, 32'h016, 32'hABCD1234, rd, er, cyc);
    do_req(1'b0, 2'd2, 1'b0, 32'h014, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'h00001234) begin
      n_fail++; $display("FAIL half_store got=%h exp=00001234", rd);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    drive(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    drive(1'b0, 2'd2, 1'b0, 32'h014, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_run++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBE55 ||
          req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d v=%b d=%h rdy=%b exp 1/deadbe55/0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release v=%b rdy=%b exp 0/1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    n_run++;
    if (rsp_rdata !== 32'h00001234 || cyc !== 3) begin
      n_fail++;
      $display("FAIL bp_second d=%h cyc=%0d exp 00001234/3", rsp_rdata, cyc);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int cyc;
    do_req(1'b1, 2'd2, 1'b0, 32'h000, 32'hCAFEF00D, rd, er, cyc);
`ifdef DMEM_ERR_CHECK_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, rd, er, cyc);
    n_run++;
    if (er !== 1'b1 || rd !== 32'h0 || cyc !== 3) begin
      n_fail++;
      $display("FAIL err_misalign e=%b d=%h cyc=%0d exp 1/0/3", er, rd, cyc);
    end
    do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h11111111, rd, er, cyc);
    n_run++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL err_range e=%b exp=1", er);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      n_fail++; $display("FAIL err_nowrite d=%h e=%b exp cafef00d/0", rd, er);
    end
    do_req(1'b0, 2'd3, 1'b0, 32'h010, 32'h0, rd, er, cyc);
    n_run++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL err_size3 e=%b d=%h exp 1/0", er, rd);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h011, 32'h0, rd, er, cyc);
    n_run++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL err_half_odd e=%b exp=1", er);
    end
`else
    do_req(1'b0, 2'd2, 1'b0, 32'h402, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      n_fail++; $display("FAIL wrap_load d=%h e=%b exp cafef00d/0", rd, er);
    end
    do_req(1'b0, 2'd3, 1'b0, 32'h010, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'hDEADBE55 || er !== 1'b0) begin
      n_fail++; $display("FAIL size3_word d=%h e=%b exp deadbe55/0", rd, er);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h011, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'h0000DEAD) begin
      n_fail++; $display("FAIL half_align d=%h exp=0000dead", rd);
    end
    do_req(1'b1, 2'd0, 1'b0, 32'h403, 32'h77, rd, er, cyc);
    do_req(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'hCAFEF077) begin
      n_fail++; $display("FAIL wrap_store d=%h exp=cafef077", rd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int cyc;
    do_req(1'b1, 2'd2, 1'b0, 32'h020, 32'hA0A0A0A0, rd, er, cyc);
    drive(1'b1, 2'd2, 1'b0, 32'h020, 32'h12345678);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait rdy=%b v=%b exp 0/0", req_ready, rsp_valid);
    end
    rst = 1'b0;
    #1;
    n_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst v=%b rdy=%b exp 0/0", rsp_valid, req_ready);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle rdy=%b v=%b exp 1/0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    do_req(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, rd, er, cyc);
    n_run++;
    if (rd !== 32'hA0A0A0A0) begin
      n_fail++; $display("FAIL mid_nowrite d=%h exp=a0a0a0a0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
